// File: rtl/adder_pkg.sv
// Shared types and helpers for the sequential adder and the ALU that reuses it.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Signed overflow: operands agree in sign but the result does not.
    function automatic logic signed_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit slice adder; time-multiplexed over the operand by the parent.
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_carry,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_carry
);

    logic [CHUNK:0] w_total;

    always_comb begin
        w_total = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_carry};
    end

    assign o_sum   = w_total[CHUNK-1:0];
    assign o_carry = w_total[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, carry rippled through a register,
// valid/ready handshakes on both operand and result sides.
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_params
        $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_carry;
    logic              r_carry_out;
    logic              r_ovf;

    int unsigned       w_base;
    logic              w_last;
    logic [CHUNK-1:0]  w_a_slice;
    logic [CHUNK-1:0]  w_b_slice;
    logic [CHUNK-1:0]  w_sum_slice;
    logic              w_carry_slice;

    always_comb begin
        w_base    = int'(r_cnt) * CHUNK;
        w_last    = (r_cnt == CW'(N - 1));
        w_a_slice = r_a[w_base +: CHUNK];
        w_b_slice = r_b[w_base +: CHUNK];
    end

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .i_a     (w_a_slice),
        .i_b     (w_b_slice),
        .i_carry (r_carry),
        .o_sum   (w_sum_slice),
        .o_carry (w_carry_slice)
    );

    always_comb begin
        w_next  = r_state;
        ready_o = 1'b0;
        valid_o = 1'b0;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) w_next = CALC;
            end
            CALC: begin
                if (w_last) w_next = DONE;
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Subtraction is folded in at accept time, so CALC only ever adds.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_carry     <= 1'b0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_a     <= a_i;
                        r_b     <= sub_i ? ~b_i : b_i;
                        r_carry <= carry_i ^ sub_i;
                        r_cnt   <= '0;
                    end
                end
                CALC: begin
                    r_sum[w_base +: CHUNK] <= w_sum_slice;
                    r_carry                <= w_carry_slice;
                    if (w_last) begin
                        r_carry_out <= w_carry_slice;
                        r_ovf       <= signed_overflow(r_a[WIDTH-1], r_b[WIDTH-1],
                                                       w_sum_slice[CHUNK-1]);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum_o      = r_sum;
    assign carry_o    = r_carry_out;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: directed vectors on 32/8, random sweeps on 16/16 and 32/1.
module tb_seq_chunk_adder;

    localparam int NCFG = 3;

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = (g == 1) ? 16 : 32;
        localparam int C = (g == 0) ? 8 : ((g == 1) ? 16 : 1);
        localparam int N = W / C;

        logic         s_rst;
        logic         s_valid;
        logic         s_ready_o;
        logic [W-1:0] s_a;
        logic [W-1:0] s_b;
        logic         s_c;
        logic         s_sub;
        logic         s_valid_o;
        logic         s_ready;
        logic [W-1:0] s_sum;
        logic         s_carry_o;
        logic         s_ovf;

        logic [W+1:0] q[$];
        logic [W+1:0] mon_exp;
        int           cyc = 0;
        int           accept_cyc = 0;
        logic         prev_valid = 1'b0;
        logic         fin = 1'b0;

        seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
            .clk_i      (clk),
            .rst_i      (s_rst),
            .valid_i    (s_valid),
            .ready_o    (s_ready_o),
            .a_i        (s_a),
            .b_i        (s_b),
            .carry_i    (s_c),
            .sub_i      (s_sub),
            .valid_o    (s_valid_o),
            .ready_i    (s_ready),
            .sum_o      (s_sum),
            .carry_o    (s_carry_o),
            .overflow_o (s_ovf)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Monitor: latency on each rising valid_o, result compared on each hand-off.
        always @(negedge clk) begin
            if (s_rst) begin
                prev_valid = 1'b0;
            end else begin
                if (s_valid_o && !prev_valid)
                    chk($sformatf("cfg%0d latency", g), 64'(cyc - accept_cyc), 64'(N));
                if (s_valid_o && s_ready) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL cfg%0d unexpected result: got 0x%0h, expected none", g,
                                 {s_ovf, s_carry_o, s_sum});
                    end else begin
                        mon_exp = q.pop_front();
                        chk($sformatf("cfg%0d result {ovf,carry,sum}", g),
                            64'({s_ovf, s_carry_o, s_sum}), 64'(mon_exp));
                    end
                end
                prev_valid = s_valid_o;
            end
        end

        function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                               input logic mc, input logic ms);
            logic [W-1:0] eb;
            logic [W:0]   t;
            logic         ov;
            eb = ms ? ~mb : mb;
            t  = {1'b0, ma} + {1'b0, eb} + {{W{1'b0}}, mc ^ ms};
            ov = (ma[W-1] == eb[W-1]) && (t[W-1] != ma[W-1]);
            return {ov, t};
        endfunction

        // Present operands until an IDLE edge accepts them; returns at accept edge + 1.
        task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                             input logic ts, input logic [W+1:0] exp, input bit push);
            logic was_ready;
            bit   ok = 1'b0;
            s_valid = 1'b1;
            s_a     = ta;
            s_b     = tb_v;
            s_c     = tc;
            s_sub   = ts;
            for (int k = 0; k < 500 && !ok; k++) begin
                was_ready = s_ready_o;
                @(posedge clk);
                #1;
                ok = was_ready;
            end
            s_valid    = 1'b0;
            accept_cyc = cyc;
            if (push) q.push_back(exp);
            if (!ok) begin
                n_checks++;
                n_errors++;
                $display("FAIL cfg%0d accept timeout: got no accept, expected accept within 500 cycles", g);
            end
        endtask

        if (g == 0) begin : g_dir
            task automatic finish_op(input string name);
                int lat = 0;
                while (!s_valid_o && lat < N + 8) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                chk({name, " wait"}, 64'(lat), 64'(N));
                s_ready = 1'b1;
                @(posedge clk);
                #1;
                s_ready = 1'b0;
                chk({name, " idle {ready,valid}"}, 64'({s_ready_o, s_valid_o}), 64'(2'b10));
            endtask

            task automatic run(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                               input logic ts, input logic [W+1:0] exp, input string name);
                s_ready = 1'b0;
                issue(ta, tb_v, tc, ts, exp, 1'b1);
                finish_op(name);
            endtask

            initial begin
                s_rst = 1'b1; s_valid = 1'b0; s_ready = 1'b0;
                s_a = '0; s_b = '0; s_c = 1'b0; s_sub = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                chk("reset state", 64'({s_ready_o, s_valid_o, s_carry_o, s_ovf, s_sum}),
                    64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
                s_rst = 1'b0;

                run(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000}, "add_wrap");
                run(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, "add_ovf");
                run(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2345_678A}, "add_cin");
                run(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, "sub_neg");
                run(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}, "sub_ovf");
                run(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0006}, "sub_bin");

                // Backpressure: result held while new operands churn on the inputs.
                s_ready = 1'b0;
                issue(32'h1, 32'h2, 1'b0, 1'b0, {2'b00, 32'h3}, 1'b1);
                for (int k = 0; k < N + 8 && !s_valid_o; k++) begin
                    @(posedge clk);
                    #1;
                end
                for (int k = 0; k < 10; k++) begin
                    s_valid = 1'b1;
                    s_a     = $urandom;
                    s_b     = $urandom;
                    s_c     = 1'($urandom_range(0, 1));
                    s_sub   = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                    chk("bp hold", 64'({s_ready_o, s_valid_o, s_carry_o, s_ovf, s_sum}),
                        64'({1'b0, 1'b1, 1'b0, 1'b0, 32'h3}));
                end
                s_a = 32'h0000_0100; s_b = 32'h0000_0023; s_c = 1'b0; s_sub = 1'b0;
                s_ready = 1'b1;
                @(posedge clk);
                #1;
                s_ready = 1'b0;
                chk("bp handoff {ready,valid}", 64'({s_ready_o, s_valid_o}), 64'(2'b10));
                @(posedge clk);
                #1;
                s_valid    = 1'b0;
                accept_cyc = cyc;
                q.push_back({2'b00, 32'h0000_0123});
                chk("bp accept {ready,valid}", 64'({s_ready_o, s_valid_o}), 64'(2'b00));
                finish_op("bp pending");

                // Reset two edges into CALC discards the partial result.
                issue(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, '0, 1'b0);
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                s_rst = 1'b1;
                @(posedge clk);
                #1;
                s_rst = 1'b0;
                chk("mid reset", 64'({s_ready_o, s_valid_o, s_carry_o, s_ovf, s_sum}),
                    64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
                run(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0007}, "post_reset");
                fin = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                s_ready = 1'b0;
                forever begin
                    @(posedge clk);
                    #1;
                    s_ready = ($urandom_range(0, 3) != 0);
                end
            end

            initial begin
                logic [W-1:0] ra;
                logic [W-1:0] rb;
                logic         rc;
                logic         rs;
                s_rst = 1'b1; s_valid = 1'b0;
                s_a = '0; s_b = '0; s_c = 1'b0; s_sub = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                chk($sformatf("cfg%0d reset state", g),
                    64'({s_ready_o, s_valid_o, s_carry_o, s_ovf, s_sum}), 64'({3'b100, 1'b0, {W{1'b0}}}));
                s_rst = 1'b0;
                for (int i = 0; i < 1000; i++) begin
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                    issue(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
                end
                for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge clk);
                chk($sformatf("cfg%0d drain", g), 64'(q.size()), 64'd0);
                fin = 1'b1;
            end
        end
    end

    initial begin
        bit all_fin = 1'b0;
        for (int k = 0; k < 80000 && !all_fin; k++) begin
            @(posedge clk);
            all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin;
        end
        if (!all_fin) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: got unfinished configurations, expected all finished");
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operand pair in CHUNK-bit slices, one slice per clock, rippling carry between cycles through a register. It trades latency for a short combinational path and replaces the single-cycle 32-bit ripple adder where timing is tight. Operands enter and results leave over valid/ready handshakes, so it can sit between pipeline stages or next to an ALU.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits added per cycle; 1 <= CHUNK <= WIDTH.
N (localparam), WIDTH/CHUNK, number of chunks, which is also the latency in cycles.

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
valid_i  in  1  operands valid
ready_o  out  1  block can accept operands (high only in IDLE)
a_i  in  WIDTH  operand A
b_i  in  WIDTH  operand B
carry_i  in  1  carry-in (add) / borrow-in (sub)
sub_i  in  1  0 = add, 1 = subtract
valid_o  out  1  result valid
ready_i  in  1  consumer accepts result
sum_o  out  WIDTH  result
carry_o  out  1  carry-out of MSB (for sub: 1 = no borrow)
overflow_o  out  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high. On a reset edge: state=IDLE, chunk counter=0, and sum_o, carry_o, overflow_o, valid_o all=0. After that edge ready_o=1. Reset overrides every other input, including in the middle of an operation; a partial result is discarded.
- Internal operand mapping:
  - eff_b = sub_i ? ~b_i : b_i
  - cin = carry_i ^ sub_i
  - so sub with carry_i=0 gives a-b, and sub with carry_i=1 gives a-b-1.
- FSM states: IDLE, CALC, DONE.
- IDLE: ready_o=1, valid_o=0.
  - On an edge with valid_i=1, latch a, eff_b and cin, clear the counter and go to CALC.
  - sum_o is not cleared on accept; it is undefined until valid_o rises.
- CALC: ready_o=0, valid_o=0.
  - Each edge computes slice k = counter, covering bits [k*CHUNK +: CHUNK], as a + eff_b + carry_reg.
  - Write the slice result into sum_o and store its carry-out in carry_reg.
  - Increment the counter.
  - On the edge processing k=N-1: set carry_o = final carry, overflow_o = (a[MSB]==eff_b[MSB]) && (sum[MSB]!=a[MSB]), and go to DONE.
- Latency: valid_o rises exactly N cycles after the accepting edge. For N=1, CALC lasts a single edge.
- DONE: valid_o=1, ready_o=0.
  - sum_o, carry_o and overflow_o are held stable while ready_i=0, for any number of cycles.
  - On an edge with ready_i=1, go to IDLE and valid_o drops. The outputs keep their values but are no longer valid.
- No overlap: a new operation cannot be accepted on the same edge as result hand-off, so the minimum issue interval is N+2 cycles.
- valid_i is ignored in CALC and DONE. valid_i may stay high continuously; the block accepts again on the first IDLE edge.
- Input operands need only be stable on the accepting edge. Later changes on a_i, b_i, sub_i and carry_i have no effect.
- Counter width: $clog2(N) bits, minimum 1. The counter never wraps past N-1.

Decomposition:
- Shared package adder_pkg holds:
  - the FSM state typedef (enum IDLE/CALC/DONE)
  - a function computing signed overflow from MSBs, reusable by the ALU.
- Sub-module adder_chunk (purely combinational, parameter CHUNK) computes the CHUNK-bit sum and carry-out from a slice, b slice and carry-in. It is instantiated once and time-multiplexed over slices by the counter.
- Parameter legality (WIDTH % CHUNK == 0) is checked with an elaboration-time assertion.

Test Plan:
- WIDTH=32, CHUNK=8: add 0xFFFFFFFF + 0x00000001, carry_i=0 -> sum_o=0x00000000, carry_o=1, overflow_o=0, valid_o high 4 cycles after accept.
- Add 0x7FFFFFFF + 0x00000001 -> sum_o=0x80000000, carry_o=0, overflow_o=1. Add 0x12345678 + 0x11111111, carry_i=1 -> sum_o=0x2345678A, carry_o=0.
- sub_i=1, carry_i=0, 0x00000005 - 0x00000007 -> sum_o=0xFFFFFFFE, carry_o=0, overflow_o=0. Then 0x80000000 - 0x00000001 -> 0x7FFFFFFF, carry_o=1, overflow_o=1.
- Backpressure: hold ready_i=0 for 10 cycles in DONE with valid_i=1 and changing operands -> valid_o=1, outputs stable, ready_o=0. After ready_i=1 -> IDLE next cycle and the pending operation is accepted on the following edge.
- Assert rst_i 2 cycles into CALC -> next cycle all outputs 0 and ready_o=1. A fresh 0x00000003 + 0x00000004 -> 0x00000007 after 4 cycles.
- Parameter sweep: WIDTH=16, CHUNK=16 -> latency 1; WIDTH=32, CHUNK=1 -> latency 32. Run 1000 random add/sub ops per configuration, with random carry_i and random ready_i, against a golden model for {carry_o, sum_o} and overflow_o.
